cordic_nco_sequencer: RTL and testbench

Phase-accumulator front end for the serial CORDIC cos/sin core. It generates a phase ramp from a frequency word and issues one start pulse per sample to the CORDIC. It waits for the core's ready, then captures cos/sin into a small first-word-fall-through output FIFO. Together with the serial core it forms a handshaked NCO sample stream.

---
 rtl/cordic_nco_sequencer.sv | 150 +++++++++++++++
 tb/tb_cordic_nco_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_nco_sequencer.sv
// cordic_nco_sequencer
//   Phase-accumulator front end for a serial CORDIC cos/sin core. Issues one
//   start pulse per sample carrying (accumulator + offset). It then waits for
//   the core's ready and captures cos/sin into a first-word-fall-through
//   output FIFO.
//
// Ports
//   clk        rising-edge clock
//   resetN     synchronous active-low reset
//   en         enable issuing new samples
//   freq       phase increment per sample (modulo 2^PHI_WIDTH)
//   phaseOfs   phase offset added to the accumulator when issuing
//   phaseClr   synchronous accumulator clear
//   cordicSt   one-cycle start pulse to the CORDIC (registered)
//   cordicPhi  angle to the CORDIC (registered, held until next issue)
//   cordicRdy  CORDIC ready; results valid while high
//   cordicCos  CORDIC cosine result
//   cordicSin  CORDIC sine result
//   outValid   FIFO non-empty
//   outReady   consumer accepts the head entry
//   outCos     FIFO head cosine (signed)
//   outSin     FIFO head sine (signed)
//   err        sticky timeout flag, cleared only by reset
module cordic_nco_sequencer #(
  parameter int unsigned PHI_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 en,
  input  logic [PHI_WIDTH-1:0] freq,
  input  logic [PHI_WIDTH-1:0] phaseOfs,
  input  logic                 phaseClr,
  output logic                 cordicSt,
  output logic [PHI_WIDTH-1:0] cordicPhi,
  input  logic                 cordicRdy,
  input  logic [PHI_WIDTH-1:0] cordicCos,
  input  logic [PHI_WIDTH-1:0] cordicSin,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [PHI_WIDTH-1:0] outCos,
  output logic [PHI_WIDTH-1:0] outSin,
  output logic                 err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           state;
  logic [PHI_WIDTH-1:0] acc;
  logic [PHI_WIDTH-1:0] base;
  logic [TW-1:0]        tcnt;

  logic [PHI_WIDTH-1:0] mem_cos [FIFO_DEPTH];
  logic [PHI_WIDTH-1:0] mem_sin [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic issue;
  logic push;
  logic pop;

  // Issuing requires a free FIFO slot; with only one transaction in flight
  // this guarantees the eventual push can never overflow.
  always_comb begin
    base  = phaseClr ? '0 : acc;
    issue = (state == S_IDLE) && en && cordicRdy && (count < DEPTH_C);
    push  = (state == S_WAIT) && cordicRdy;
    pop   = outValid && outReady;
  end

  assign outValid = (count != '0);
  assign outCos   = mem_cos[rd_ptr];
  assign outSin   = mem_sin[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= S_IDLE;
      acc       <= '0;
      cordicSt  <= 1'b0;
      cordicPhi <= '0;
      tcnt      <= '0;
      err       <= 1'b0;
    end else begin
      // phaseClr acts in every state; an issue overrides with base+freq.
      acc <= base;
      case (state)
        S_IDLE: begin
          if (issue) begin
            state     <= S_ISSUE;
            cordicSt  <= 1'b1;
            cordicPhi <= base + phaseOfs;
            acc       <= base + freq;
          end
        end
        S_ISSUE: begin
          cordicSt <= 1'b0;
          tcnt     <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cordicRdy) begin
            state <= S_IDLE;
          end else if (tcnt == TMAX) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_cos[AW'(i)] <= '0;
        mem_sin[AW'(i)] <= '0;
      end
    end else begin
      if (push) begin
        mem_cos[wr_ptr] <= cordicCos;
        mem_sin[wr_ptr] <= cordicSin;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_nco_sequencer.sv
// tb_cordic_nco_sequencer
//   Self-checking bench for cordic_nco_sequencer. A behavioural serial CORDIC
//   answers each start pulse after LAT cycles. The stimulus side keeps its own
//   phase accumulator and queues the phases it expects to be issued. Each
//   expected cos/sin is queued when the core delivers a result that should be
//   kept, and is popped and compared when the FIFO hands an entry out.
module tb_cordic_nco_sequencer;

  localparam int PW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int LAT   = 6;

  logic          clk = 1'b0;
  logic          resetN, en, phaseClr, outReady;
  logic [PW-1:0] freq, phaseOfs;
  logic          cordicSt, cordicRdy, outValid, err;
  logic [PW-1:0] cordicPhi, cordicCos, cordicSin, outCos, outSin;

  always #5 clk = ~clk;

  cordic_nco_sequencer #(
    .PHI_WIDTH (PW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .en       (en),
    .freq     (freq),
    .phaseOfs (phaseOfs),
    .phaseClr (phaseClr),
    .cordicSt (cordicSt),
    .cordicPhi(cordicPhi),
    .cordicRdy(cordicRdy),
    .cordicCos(cordicCos),
    .cordicSin(cordicSin),
    .outValid (outValid),
    .outReady (outReady),
    .outCos   (outCos),
    .outSin   (outSin),
    .err      (err)
  );

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] phi_q [$];
  logic [31:0]   data_q [$];

  // Core model and scoreboard state.
  bit            busy = 1'b0;
  bit            stall = 1'b0;
  bit            discard = 1'b0;
  bit            period_chk = 1'b0;
  int            mcnt = 0;
  int            cyc = 0;
  int            st_count = 0;
  int            last_st = -1;
  logic [PW-1:0] pend_phi = '0;
  logic [PW-1:0] act_phi = '0;
  logic [PW-1:0] model_acc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cs_of(input logic [PW-1:0] phi);
    real a, c, s;
    int  ci, si;
    a  = 2.0 * 3.14159265358979 * real'(phi) / 65536.0;
    c  = 32767.0 * $cos(a);
    s  = 32767.0 * $sin(a);
    ci = $rtoi(c >= 0.0 ? c + 0.5 : c - 0.5);
    si = $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
    return {ci[15:0], si[15:0]};
  endfunction

  // Serial core model plus output monitor, evaluated mid-cycle.
  initial begin
    logic [PW-1:0] ep;
    logic [31:0]   ed;
    cordicRdy = 1'b1;
    cordicCos = '0;
    cordicSin = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cordicSt === 1'b1) begin
        st_count++;
        check("st_rdy", cordicRdy, 1);
        check("st_expected", phi_q.size() > 0, 1);
        if (phi_q.size() > 0) begin
          ep = phi_q.pop_front();
          check("phi", cordicPhi, ep);
          pend_phi = ep;
        end
        if (period_chk && last_st >= 0) check("period", cyc - last_st, LAT + 2);
        last_st   = cyc;
        act_phi   = cordicPhi;
        busy      = 1'b1;
        mcnt      = LAT;
        cordicRdy = 1'b0;
      end else if (busy && !stall) begin
        mcnt--;
        if (mcnt == 0) begin
          busy      = 1'b0;
          cordicRdy = 1'b1;
          {cordicCos, cordicSin} = cs_of(act_phi);
          if (discard) discard = 1'b0;
          else data_q.push_back(cs_of(pend_phi));
        end
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        check("pop_expected", data_q.size() > 0, 1);
        if (data_q.size() > 0) begin
          ed = data_q.pop_front();
          check("cos", outCos, ed[31:16]);
          check("sin", outSin, ed[15:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_st(input int target, input int budget);
    int k = 0;
    while (st_count < target && k < budget) begin
      step(1);
      k++;
    end
    check("st_count", st_count, target);
  endtask

  // Queue n expected phases, enable until the n-th start, then drop en.
  task automatic run(input int n, input bit clr);
    int target;
    if (clr) begin
      model_acc = '0;
      phaseClr  = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      phi_q.push_back(PW'(model_acc + phaseOfs));
      model_acc = PW'(model_acc + freq);
    end
    target = st_count + n;
    en = 1'b1;
    if (clr) begin
      step(1);
      phaseClr = 1'b0;
    end
    wait_st(target, n * (LAT + 2) + 20);
    en = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    outReady = 1'b1;
    while ((data_q.size() != 0 || busy) && k < 200) begin
      step(1);
      k++;
    end
    step(2);
    check("drain_q", data_q.size(), 0);
    check("drain_valid", outValid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_st"},    cordicSt,  0);
    check({tag, "_phi"},   cordicPhi, 0);
    check({tag, "_valid"}, outValid,  0);
    check({tag, "_cos"},   outCos,    0);
    check({tag, "_sin"},   outSin,    0);
    check({tag, "_err"},   err,       0);
  endtask

  initial begin
    int base;
    resetN = 1'b0; en = 1'b0; phaseClr = 1'b0; outReady = 1'b1;
    freq = '0; phaseOfs = '0;
    step(3);
    check_reset_outputs("rst");
    resetN = 1'b1;
    step(2);

    // Ramp with wrap, continuous streaming, period L+2.
    freq = 16'h1000; phaseOfs = '0;
    period_chk = 1'b1; last_st = -1;
    run(18, 1'b0);
    period_chk = 1'b0;
    drain();

    // Back-pressure: FIFO fills, then one pop allows exactly one issue.
    outReady = 1'b0;
    base = st_count;
    for (int i = 0; i < DEPTH + 1; i++) begin
      phi_q.push_back(PW'(model_acc + phaseOfs));
      model_acc = PW'(model_acc + freq);
    end
    en = 1'b1;
    step(60);
    check("bp_issues", st_count - base, DEPTH);
    check("bp_full", outValid, 1);
    outReady = 1'b1;
    step(1);
    outReady = 1'b0;
    step(30);
    check("bp_one_more", st_count - base, DEPTH + 1);
    en = 1'b0;
    drain();

    // phaseClr on the issue edge plus offset; en dropped after each start.
    freq = 16'h0100; phaseOfs = 16'h4000;
    run(3, 1'b1);
    base = st_count;
    step(20);
    check("en_drop_no_st", st_count, base);
    drain();

    // Timeout: core never answers; err after TIMEOUT wait cycles, no push.
    stall = 1'b1;
    run(1, 1'b0);
    step(TMO - 1);
    check("err_before_timeout", err, 0);
    step(1);
    check("err_at_timeout", err, 1);
    check("timeout_no_push", outValid, 0);
    discard = 1'b1;
    stall = 1'b0;
    step(LAT + 4);
    check("stale_no_push", outValid, 0);
    run(1, 1'b0);
    drain();
    check("err_sticky", err, 1);

    // Reset while the core is busy: stale result dropped, restart from offset.
    run(1, 1'b0);
    step(2);
    discard = 1'b1;
    resetN = 1'b0;
    step(1);
    resetN = 1'b1;
    check_reset_outputs("rst_wait");
    model_acc = '0;
    freq = 16'h0777; phaseOfs = 16'h2345;
    run(1, 1'b0);
    drain();
    check("phi_q_empty", phi_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
